// File: rtl/mem_org_csr_pkg.sv
// Purpose: shared types and constants for the memory-organisation CSR.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_org_csr_pkg;

    // Commit sequencer states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // STATUS register bit positions.
    localparam int PENDING_BIT = 0;
    localparam int BUSY_BIT    = 1;
    localparam int DONE_BIT    = 2;

    // STATUS sits directly after the last channel mode register.
    function automatic int status_addr(input int num_channels);
        return num_channels;
    endfunction

endpackage

// File: rtl/mem_org_idle_qualifier.sv
// Purpose: counts consecutive kernel_idle cycles and flags the cycle that completes a full run.
// Latency: o_qualified is combinational from the registered count and the current i_idle.
// Backpressure: none; the counter restarts whenever i_idle drops or i_clear is high.
//
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   i_clear      - hold counter at zero (asserted outside the counting state)
//   i_count_en   - counting window is open
//   i_idle       - kernel memory interface quiescent this cycle
//   o_qualified  - this cycle is the IDLE_CYCLES-th consecutive idle cycle
module mem_org_idle_qualifier #(
    parameter int IDLE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_count_en,
    input  logic i_idle,
    output logic o_qualified
);

    localparam int CNT_W = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(IDLE_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    // Saturates at LAST so a long idle run never wraps back to zero.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_count <= '0;
        end else if (i_count_en) begin
            if (!i_idle) begin
                r_count <= '0;
            end else if (r_count != LAST) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign o_qualified = i_count_en && i_idle && (r_count == LAST);

endmodule

// File: rtl/mem_org_csr.sv
// Purpose: multi-channel memory-organisation mode CSR with a drained, atomic kernel-side commit.
// Latency: reads return 1 cycle after acceptance; host conduit 1 cycle after write; kernel conduit after IDLE_CYCLES idle cycles + commit.
// Backpressure: waitrequest stalls writes only during the single COMMIT cycle; reads are accepted otherwise.
//
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   slave_*                    - Avalon-MM slave (word addressed, registered readdata)
//   kernel_idle                - kernel memory interface quiescent
//   mem_organization_host      - shadow modes, channel i at [i*CONDUIT_WIDTH +: CONDUIT_WIDTH]
//   mem_organization_kernel    - committed modes, same packing, updated atomically
//   commit_busy                - commit sequence in progress
//   irq                        - (MEM_ORG_CSR_IRQ_EN only) commit_done && irq_enable
//
// Optional feature macro: MEM_ORG_CSR_IRQ_EN adds a sticky commit_done flag (STATUS bit2, W1C),
// an irq_enable register at address NUM_CHANNELS+1 and the irq output.
module mem_org_csr
    import mem_org_csr_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int CONDUIT_WIDTH = 2,
    parameter int NUM_CHANNELS  = 2,
    parameter int ADDR_WIDTH    = 2,
    parameter int IDLE_CYCLES   = 4
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [ADDR_WIDTH-1:0]                  slave_address,
    input  logic [WIDTH-1:0]                       slave_writedata,
    input  logic                                   slave_read,
    input  logic                                   slave_write,
    output logic [WIDTH-1:0]                       slave_readdata,
    output logic                                   slave_readdatavalid,
    output logic                                   slave_waitrequest,
    input  logic                                   kernel_idle,
    output logic [NUM_CHANNELS*CONDUIT_WIDTH-1:0]  mem_organization_host,
    output logic [NUM_CHANNELS*CONDUIT_WIDTH-1:0]  mem_organization_kernel,
    output logic                                   commit_busy
`ifdef MEM_ORG_CSR_IRQ_EN
    ,
    output logic                                   irq
`endif
);

    localparam int MODE_W      = NUM_CHANNELS * CONDUIT_WIDTH;
    localparam int STATUS_ADDR = status_addr(NUM_CHANNELS);
    localparam logic [ADDR_WIDTH-1:0] STATUS_A = ADDR_WIDTH'(STATUS_ADDR);
`ifdef MEM_ORG_CSR_IRQ_EN
    localparam logic [ADDR_WIDTH-1:0] IRQEN_A  = ADDR_WIDTH'(STATUS_ADDR + 1);
`endif

    state_t                   r_state;
    logic [MODE_W-1:0]        r_shadow;
    logic [MODE_W-1:0]        r_committed;
    logic                     r_pending;
    logic                     r_busy;
    logic [WIDTH-1:0]         r_readdata;
    logic                     r_readdatavalid;
`ifdef MEM_ORG_CSR_IRQ_EN
    logic                     r_commit_done;
    logic                     r_irq_en;
`endif

    logic                     w_waitreq;
    logic                     w_rd_acc;
    logic                     w_wr_acc;
    logic                     w_ch_hit;
    logic                     w_changed;
    logic                     w_qualified;
    logic [CONDUIT_WIDTH-1:0] w_wr_mode;
    logic [CONDUIT_WIDTH-1:0] w_cur_mode;
    logic [WIDTH-1:0]         w_rd_val;
    logic [MODE_W-1:0]        w_shadow_nxt;
    logic                     w_unused_wdata;

    // Only writes are stalled, and only while the committed copy is being taken,
    // so a write can never race the shadow snapshot.
    assign w_waitreq = (r_state == COMMIT) && slave_write;
    assign w_rd_acc  = slave_read  && !w_waitreq;
    assign w_wr_acc  = slave_write && !w_waitreq;
    assign w_wr_mode = slave_writedata[CONDUIT_WIDTH-1:0];

    // Upper write-data bits are intentionally ignored.
    assign w_unused_wdata = ^slave_writedata;

    // Channel decode and current shadow value of the addressed channel.
    always_comb begin
        w_ch_hit   = 1'b0;
        w_cur_mode = '0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            if (slave_address == ADDR_WIDTH'(ch)) begin
                w_ch_hit   = 1'b1;
                w_cur_mode = r_shadow[ch*CONDUIT_WIDTH +: CONDUIT_WIDTH];
            end
        end
    end

    // Rewriting an identical mode must not start a commit.
    assign w_changed = w_ch_hit && (w_wr_mode != w_cur_mode);

    always_comb begin
        w_shadow_nxt = r_shadow;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            if (w_wr_acc && (slave_address == ADDR_WIDTH'(ch))) begin
                w_shadow_nxt[ch*CONDUIT_WIDTH +: CONDUIT_WIDTH] = w_wr_mode;
            end
        end
    end

    // Read mux uses pre-write register values, so a same-cycle read/write
    // returns the old contents.
    always_comb begin
        w_rd_val = '0;
        if (w_ch_hit) begin
            w_rd_val[CONDUIT_WIDTH-1:0] = w_cur_mode;
        end else if (slave_address == STATUS_A) begin
            w_rd_val[PENDING_BIT] = r_pending;
            w_rd_val[BUSY_BIT]    = r_busy;
`ifdef MEM_ORG_CSR_IRQ_EN
            w_rd_val[DONE_BIT]    = r_commit_done;
        end else if (slave_address == IRQEN_A) begin
            w_rd_val[0]           = r_irq_en;
`endif
        end
    end

    mem_org_idle_qualifier #(
        .IDLE_CYCLES (IDLE_CYCLES)
    ) u_idle_qual (
        .clk         (clk),
        .reset       (reset),
        .i_clear     (r_state != DRAIN),
        .i_count_en  (r_state == DRAIN),
        .i_idle      (kernel_idle),
        .o_qualified (w_qualified)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= IDLE;
            r_shadow        <= '0;
            r_committed     <= '0;
            r_pending       <= 1'b0;
            r_busy          <= 1'b0;
            r_readdata      <= '0;
            r_readdatavalid <= 1'b0;
`ifdef MEM_ORG_CSR_IRQ_EN
            r_commit_done   <= 1'b0;
            r_irq_en        <= 1'b0;
`endif
        end else begin
            r_readdatavalid <= w_rd_acc;
            if (w_rd_acc) begin
                r_readdata <= w_rd_val;
            end

            r_shadow <= w_shadow_nxt;

            // r_busy tracks the next state so commit_busy equals (state != IDLE).
            unique case (r_state)
                IDLE: begin
                    if (r_pending) begin
                        r_state <= DRAIN;
                        r_busy  <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (w_qualified) begin
                        r_state <= COMMIT;
                    end
                end
                COMMIT: begin
                    r_committed <= r_shadow;
                    r_state     <= IDLE;
                    r_busy      <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase

            // Writes are held off in COMMIT, so clear and set never collide.
            if (r_state == COMMIT) begin
                r_pending <= 1'b0;
            end else if (w_wr_acc && w_changed) begin
                r_pending <= 1'b1;
            end

`ifdef MEM_ORG_CSR_IRQ_EN
            // Set has priority over a same-edge W1C.
            if (r_state == COMMIT) begin
                r_commit_done <= 1'b1;
            end else if (w_wr_acc && (slave_address == STATUS_A) && slave_writedata[DONE_BIT]) begin
                r_commit_done <= 1'b0;
            end
            if (w_wr_acc && (slave_address == IRQEN_A)) begin
                r_irq_en <= slave_writedata[0];
            end
`endif
        end
    end

    assign slave_readdata          = r_readdata;
    assign slave_readdatavalid     = r_readdatavalid;
    assign slave_waitrequest       = w_waitreq;
    assign mem_organization_host   = r_shadow;
    assign mem_organization_kernel = r_committed;
    assign commit_busy             = r_busy;
`ifdef MEM_ORG_CSR_IRQ_EN
    assign irq                     = r_commit_done && r_irq_en;
`endif

endmodule

// File: tb/tb_mem_org_csr.sv
// Purpose: self-checking bench for mem_org_csr against a behavioural register/commit model.
// Latency: n/a.
// Backpressure: writes are retried while waitrequest is high.
module tb_mem_org_csr;

    localparam int WIDTH = 32;
    localparam int CW    = 2;
    localparam int NCH   = 2;
    localparam int AW    = 2;
    localparam int IC    = 4;
    localparam int MW    = NCH * CW;

    logic              clk;
    logic              reset;
    logic [AW-1:0]     slave_address;
    logic [WIDTH-1:0]  slave_writedata;
    logic              slave_read;
    logic              slave_write;
    logic [WIDTH-1:0]  slave_readdata;
    logic              slave_readdatavalid;
    logic              slave_waitrequest;
    logic              kernel_idle;
    logic [MW-1:0]     mem_organization_host;
    logic [MW-1:0]     mem_organization_kernel;
    logic              commit_busy;
`ifdef MEM_ORG_CSR_IRQ_EN
    logic              irq;
`endif

    mem_org_csr #(
        .WIDTH         (WIDTH),
        .CONDUIT_WIDTH (CW),
        .NUM_CHANNELS  (NCH),
        .ADDR_WIDTH    (AW),
        .IDLE_CYCLES   (IC)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .slave_address           (slave_address),
        .slave_writedata         (slave_writedata),
        .slave_read              (slave_read),
        .slave_write             (slave_write),
        .slave_readdata          (slave_readdata),
        .slave_readdatavalid     (slave_readdatavalid),
        .slave_waitrequest       (slave_waitrequest),
        .kernel_idle             (kernel_idle),
        .mem_organization_host   (mem_organization_host),
        .mem_organization_kernel (mem_organization_kernel),
        .commit_busy             (commit_busy)
`ifdef MEM_ORG_CSR_IRQ_EN
        ,
        .irq                     (irq)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_phase: 0 = no commit in flight, 1 = waiting for an idle run, 2 = commit this edge.
    int               m_phase;
    int               m_run;
    bit               m_pending;
    logic [MW-1:0]    m_host;
    logic [MW-1:0]    m_kern;
    bit               m_rdv;
    logic [WIDTH-1:0] m_rdata;
    bit               m_done;
    bit               m_irqen;
    bit               m_ok = 1'b0;

    always @(posedge clk) begin : model
        bit               stall;
        bit               racc;
        bit               wacc;
        int               a;
        logic [WIDTH-1:0] v;
        if (reset) begin
            m_phase = 0; m_run = 0; m_pending = 0;
            m_host = '0; m_kern = '0; m_rdv = 0; m_rdata = '0;
            m_done = 0; m_irqen = 0; m_ok = 1'b1;
        end else if (m_ok) begin
            a     = int'(slave_address);
            stall = slave_write && (m_phase == 2);
            racc  = slave_read && !stall;
            wacc  = slave_write && !stall;

            v = '0;
            if (a < NCH) begin
                v[CW-1:0] = m_host[a*CW +: CW];
            end else if (a == NCH) begin
                v[0] = m_pending;
                v[1] = (m_phase != 0);
`ifdef MEM_ORG_CSR_IRQ_EN
                v[2] = m_done;
            end else if (a == NCH + 1) begin
                v[0] = m_irqen;
`endif
            end
            m_rdv = racc;
            if (racc) m_rdata = v;

            // W1C first so a same-edge commit set wins.
            if (wacc && a == NCH && slave_writedata[2]) m_done = 0;
            if (wacc && a == NCH + 1) m_irqen = slave_writedata[0];

            if (m_phase == 2) begin
                m_kern = m_host;
                m_pending = 0;
                m_done = 1;
                m_phase = 0;
            end else if (m_phase == 1) begin
                if (kernel_idle) begin
                    m_run++;
                    if (m_run == IC) m_phase = 2;
                end else begin
                    m_run = 0;
                end
            end else if (m_pending) begin
                m_phase = 1;
                m_run = 0;
            end

            if (wacc && a < NCH) begin
                if (m_host[a*CW +: CW] != slave_writedata[CW-1:0]) m_pending = 1;
                m_host[a*CW +: CW] = slave_writedata[CW-1:0];
            end
        end
    end

    // ---------------- compare process (just before each rising edge) ----------------
    always @(negedge clk) begin
        #4;
        if (m_ok) begin
            chk("host", mem_organization_host, m_host);
            chk("kernel", mem_organization_kernel, m_kern);
            chk("busy", commit_busy, (m_phase != 0));
            chk("rdvalid", slave_readdatavalid, m_rdv);
            if (m_rdv) chk("rdata", slave_readdata, m_rdata);
            chk("waitreq", slave_waitrequest, slave_write && (m_phase == 2));
`ifdef MEM_ORG_CSR_IRQ_EN
            chk("irq", irq, m_done && m_irqen);
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic bus_write(input int a, input logic [WIDTH-1:0] d);
        int n;
        n = 0;
        @(negedge clk);
        slave_address = AW'(a); slave_writedata = d; slave_write = 1'b1; slave_read = 1'b0;
        #3;
        while (slave_waitrequest && n < 8) begin
            @(negedge clk); #3; n++;
        end
        if (n == 8) chk("write_stall_bound", slave_waitrequest, 1'b0);
        @(posedge clk); #1;
        slave_write = 1'b0;
    endtask

    task automatic bus_read(input int a, output logic [WIDTH-1:0] d, output logic vld);
        @(negedge clk);
        slave_address = AW'(a); slave_read = 1'b1; slave_write = 1'b0;
        @(posedge clk); #1;
        slave_read = 1'b0;
        d = slave_readdata; vld = slave_readdatavalid;
    endtask

    task automatic wait_kernel(input logic [MW-1:0] exp, input int max, output int n);
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (mem_organization_kernel !== exp && n < max);
    endtask

    task automatic pulse_reset();
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    logic [WIDTH-1:0] rd;
    logic             rv;
    int               n;
    logic [7:0]       pat;

    initial begin
        reset = 1'b1; slave_address = '0; slave_writedata = '0;
        slave_read = 1'b0; slave_write = 1'b0; kernel_idle = 1'b0;
        repeat (3) @(posedge clk);
        #1; reset = 1'b0;

        // Reset state and first read.
        bus_read(0, rd, rv);
        chk("rst_rd_valid", rv, 1'b1);
        chk("rst_rd_data", rd, 0);
        chk("rst_host", mem_organization_host, 0);
        chk("rst_kernel", mem_organization_kernel, 0);
        chk("rst_busy", commit_busy, 1'b0);

        // Basic commit with kernel idle: ch1 = 2.
        kernel_idle = 1'b1;
        bus_write(1, 32'hFFFF_FFF2);
        chk("host_ch1", mem_organization_host, 4'h8);
        wait_kernel(4'h8, 20, n);
        chk("commit_latency", n, 6);
        chk("kernel_ch1", mem_organization_kernel, 4'h8);
        bus_read(NCH, rd, rv);
        chk("status_after_commit", rd, 0);

        // kernel_idle held low: no commit, STATUS pending|busy.
        kernel_idle = 1'b0;
        bus_write(0, 1);
        repeat (20) @(posedge clk);
        #1;
        chk("kernel_held", mem_organization_kernel, 4'h8);
        bus_read(NCH, rd, rv);
        chk("status_draining", rd, 3);
        @(negedge clk); kernel_idle = 1'b1;
        wait_kernel(4'h9, 20, n);
        chk("commit_after_idle", n, 5);

        // Idle run broken once during DRAIN.
        bus_write(1, 1);
        @(negedge clk); kernel_idle = 1'b1;
        pat = 8'b1110_1111;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); kernel_idle = pat[7-i];
        end
        @(posedge clk); #1;
        chk("kernel_before_run_done", mem_organization_kernel, 4'h9);
        @(negedge clk); kernel_idle = 1'b1;
        @(posedge clk); #1;
        chk("kernel_after_run_done", mem_organization_kernel, 4'h5);

        // Write during DRAIN, then a write landing on the COMMIT cycle.
        bus_write(0, 2);
        @(posedge clk); #1;
        bus_write(0, 3);
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        slave_address = AW'(1); slave_writedata = 3; slave_write = 1'b1;
        #3;
        chk("commit_stall", slave_waitrequest, 1'b1);
        @(posedge clk); #1;
        chk("first_commit", mem_organization_kernel, 4'h7);
        @(negedge clk); #3;
        chk("stall_released", slave_waitrequest, 1'b0);
        @(posedge clk); #1;
        slave_write = 1'b0;
        chk("host_after_stall", mem_organization_host, 4'hF);
        wait_kernel(4'hF, 20, n);
        chk("second_commit_latency", n, 6);

        // Simultaneous read and write returns the pre-write value.
        @(negedge clk);
        slave_address = AW'(0); slave_writedata = 1; slave_read = 1'b1; slave_write = 1'b1;
        @(posedge clk); #1;
        slave_read = 1'b0; slave_write = 1'b0;
        chk("rw_same_cycle_old", slave_readdata, 3);
        chk("rw_same_cycle_host", mem_organization_host, 4'hD);
        wait_kernel(4'hD, 20, n);
        chk("rw_commit", mem_organization_kernel, 4'hD);

`ifdef MEM_ORG_CSR_IRQ_EN
        chk("irq_masked", irq, 1'b0);
        bus_write(NCH + 1, 1);
        chk("irq_enabled", irq, 1'b1);
        bus_read(NCH + 1, rd, rv);
        chk("irqen_readback", rd, 1);
        bus_read(NCH, rd, rv);
        chk("status_done", rd, 4);
        bus_write(NCH, 4);
        chk("irq_cleared", irq, 1'b0);
        bus_read(NCH, rd, rv);
        chk("status_done_cleared", rd, 0);
`else
        bus_write(NCH + 1, 1);
        bus_read(NCH + 1, rd, rv);
        chk("unmapped_read", rd, 0);
        bus_read(NCH, rd, rv);
        chk("status_no_done", rd, 0);
`endif

        // Reset in the middle of DRAIN discards everything.
        pulse_reset();
        bus_write(0, 3);
        repeat (2) @(posedge clk);
        #1;
        chk("busy_in_drain", commit_busy, 1'b1);
        pulse_reset();
        chk("rst_drain_host", mem_organization_host, 0);
        chk("rst_drain_kernel", mem_organization_kernel, 0);
        chk("rst_drain_busy", commit_busy, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        chk("rst_drain_no_commit", mem_organization_kernel, 0);

        // Randomized traffic checked by the compare process.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            reset           = ($urandom_range(0, 499) == 0);
            slave_address   = AW'($urandom_range(0, (1 << AW) - 1));
            slave_writedata = $urandom;
            slave_read      = ($urandom_range(0, 2) == 0);
            slave_write     = ($urandom_range(0, 2) == 0);
            kernel_idle     = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        reset = 1'b0; slave_read = 1'b0; slave_write = 1'b0; kernel_idle = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("final_kernel_settled", mem_organization_kernel, m_host);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_org_csr.md
Name: mem_org_csr

Overview:
- Multi-channel, Avalon-MM-slave CSR for memory-organisation mode; one CONDUIT_WIDTH mode field per global-memory channel.
- Host-side conduit follows host writes immediately. Kernel-side conduit only changes through a drain/commit handshake, once the kernel interface has been quiescent for IDLE_CYCLES consecutive cycles.
- Sits between the host-facing MM interconnect and the kernel memory-interconnect mode conduits.

Parameters:
- WIDTH, 32, slave data width; must be >= CONDUIT_WIDTH and >= 2.
- CONDUIT_WIDTH, 2, mode bits per channel.
- NUM_CHANNELS, 2, number of mode channels; must be >= 1.
- ADDR_WIDTH, 2, word address width; 2**ADDR_WIDTH must be > NUM_CHANNELS.
- IDLE_CYCLES, 4, consecutive kernel_idle cycles needed before commit; must be >= 1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- slave_address  in  ADDR_WIDTH  word address
- slave_writedata  in  WIDTH  write data
- slave_read  in  1  read request
- slave_write  in  1  write request
- slave_readdata  out  WIDTH  registered read data
- slave_readdatavalid  out  1  read data valid
- slave_waitrequest  out  1  stall
- kernel_idle  in  1  kernel memory interface quiescent
- mem_organization_host  out  NUM_CHANNELS*CONDUIT_WIDTH  shadow modes; channel i in bits [i*CONDUIT_WIDTH +: CONDUIT_WIDTH]
- mem_organization_kernel  out  NUM_CHANNELS*CONDUIT_WIDTH  committed modes; same packing
- commit_busy  out  1  commit sequence in progress

Behaviour:
- Single clock. Reset is synchronous and active-high.
- Reset values: all shadow and committed modes 0; readdata 0; readdatavalid 0; waitrequest 0; commit_busy 0; pending 0; idle counter 0; FSM IDLE.
- Register map:
  - Addresses 0..NUM_CHANNELS-1: channel mode. R/W. Writes take writedata[CONDUIT_WIDTH-1:0]; upper bits are ignored.
  - Address NUM_CHANNELS: STATUS. Read-only. Bit0 = pending, bit1 = commit_busy, other bits 0.
  - Other addresses: read 0, writes ignored.
- Reads: accepted when slave_read && !waitrequest. slave_readdata is zero-extended and valid with readdatavalid exactly 1 cycle later. readdatavalid is a 1-cycle pulse per accepted read.
- Writes: accepted when slave_write && !waitrequest. Shadow is updated on the accepting edge; mem_organization_host shows the new value the next cycle.
- A channel write that changes the shadow value sets pending. Rewriting the same value does not set pending.
- Simultaneous read and write in one cycle: both accepted; the read returns the pre-write value.
- waitrequest is high only while FSM is in COMMIT and the access is a write; reads are never stalled.
- FSM states:
  - IDLE: when pending, go to DRAIN with counter cleared.
  - DRAIN: counter increments while kernel_idle is high and clears to 0 when it drops. When counter reaches IDLE_CYCLES-1 with kernel_idle high, go to COMMIT. Host writes are still accepted; the latest shadow is what gets committed.
  - COMMIT (1 cycle): committed <= shadow, pending cleared, go to IDLE.
- A write accepted on the COMMIT edge cannot occur, because waitrequest holds it off.
- Pending set again after COMMIT starts a new DRAIN from IDLE.
- commit_busy = (state != IDLE), registered.
- Kernel outputs change only on a COMMIT edge, and all channels change atomically.
- Reset asserted mid-DRAIN or mid-COMMIT: everything returns to reset values next edge; nothing is committed.
- kernel_idle held low indefinitely: stay in DRAIN. There is no timeout.

Optional Feature:
- Macro: MEM_ORG_CSR_IRQ_EN.
- When defined:
  - Extra output port irq (1 bit).
  - STATUS bit2 = commit_done sticky flag, set on the COMMIT edge.
  - irq = commit_done && irq_enable, where irq_enable is a R/W bit at address NUM_CHANNELS+1, bit0, reset 0.
  - Writing 1 to STATUS bit2 clears commit_done. If a clear and a set land on the same edge, set wins.
  - 2**ADDR_WIDTH must be > NUM_CHANNELS+1.
- When undefined: no irq port; STATUS bit2 reads 0; address NUM_CHANNELS+1 behaves as unmapped.

Decomposition:
- Package mem_org_csr_pkg holds:
  - state enum {IDLE, DRAIN, COMMIT}
  - STATUS bit-index constants (PENDING_BIT = 0, BUSY_BIT = 1, DONE_BIT = 2)
  - function computing STATUS_ADDR from NUM_CHANNELS
- One sub-module is natural: mem_org_idle_qualifier, a saturating consecutive-idle counter with parameter IDLE_CYCLES. It outputs a qualified pulse and is cleared on state entry.

Test Plan:
- Reset release, read address 0 -> readdatavalid 1 cycle later with readdata 0. Both conduits 0 and commit_busy 0.
- Write 0x2 to channel 1 with kernel_idle=1 and IDLE_CYCLES=4 -> host conduit bits[3:2]=2 next cycle. Kernel conduit changes 5-6 cycles after the write (DRAIN 4 cycles + COMMIT); STATUS then reads 0.
- Write 0x1 to channel 0, then hold kernel_idle low for 20 cycles -> kernel conduit stays 0 and STATUS reads 0x3. Raise kernel_idle -> commit after 4 idle cycles.
- Toggle kernel_idle 1,1,1,0,1,1,1,1 during DRAIN -> counter restarts at the 0; commit only after the final 4-cycle run.
- Write channel 0 during DRAIN, then write channel 1 exactly on the COMMIT cycle -> second write sees waitrequest=1 for 1 cycle and lands after commit. pending re-sets and a second commit follows.
- Assert reset in DRAIN after write 0x3 -> kernel conduit stays 0 and the host conduit returns to 0. With MEM_ORG_CSR_IRQ_EN: after a commit, irq rises only when irq_enable=1, and clears on W1C of STATUS bit2.
